if_pipe_skid_reg: RTL

- Parametrised IF/ID pipeline register, successor to the plain freeze/flush stage register.
- Adds ready/valid handshake on both sides, a 2-entry skid buffer so the fetch side sees a registered ready, bubble (NOP) insertion, and a saturating killed-instruction counter.
- Sits between the IF stage (PC + instruction memory) and the ID stage.

---
 rtl/if_pipe_skid_reg.sv | 92 +++++++++
 1 files changed

// File: rtl/if_pipe_skid_reg.sv
// IF/ID pipeline register with ready/valid handshake on both sides and a 2-entry skid buffer.
// Flush discards both entries and adds them to a saturating kill counter.
module if_pipe_skid_reg #(
  parameter int unsigned         PC_W      = 32,
  parameter int unsigned         INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
  parameter int unsigned         CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               freeze,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   flush_kill_count
);

  logic               r_main_valid;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_main_instr;
  logic               r_skid_valid;
  logic [PC_W-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [CNT_W-1:0]   r_kill_cnt;

  logic               w_acc;
  logic               w_drn;
  logic [CNT_W:0]     w_cnt_sum;

  // in_ready is a pure function of state, so the IF side never sees a combinational path.
  assign in_ready  = ~r_skid_valid;
  assign w_acc     = in_valid & in_ready & ~flush;
  assign w_drn     = r_main_valid & out_ready & ~freeze;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign w_cnt_sum = {1'b0, r_kill_cnt} + (CNT_W+1)'(occupancy);

  assign out_valid        = r_main_valid;
  assign out_pc           = r_main_valid ? r_main_pc : '0;
  assign out_instr        = r_main_valid ? r_main_instr : NOP_INSTR;
  assign flush_kill_count = r_kill_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_instr <= NOP_INSTR;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
      r_kill_cnt   <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_instr <= NOP_INSTR;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
      r_kill_cnt   <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end else if (!r_main_valid) begin
      if (w_acc) begin
        r_main_valid <= 1'b1;
        r_main_pc    <= in_pc;
        r_main_instr <= in_instr;
      end
    end else if (!r_skid_valid) begin
      if (w_drn) begin
        r_main_valid <= w_acc;
        r_main_pc    <= w_acc ? in_pc : '0;
        r_main_instr <= w_acc ? in_instr : NOP_INSTR;
      end else if (w_acc) begin
        r_skid_valid <= 1'b1;
        r_skid_pc    <= in_pc;
        r_skid_instr <= in_instr;
      end
    end else if (w_drn) begin
      // Skid is older than any new input, so it moves up before anything else is taken.
      r_main_pc    <= r_skid_pc;
      r_main_instr <= r_skid_instr;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
    end
  end

endmodule
